// File: rtl/gpu_pkg.sv
// gpu_pkg: shared screen geometry, pixel entry type and writer FSM states.
package gpu_pkg;
    localparam int SCREEN_W   = 640;
    localparam int SCREEN_H   = 480;
    localparam int PIX_COUNT  = SCREEN_W * SCREEN_H;
    localparam int PIX_ADDR_W = 19;
    localparam int COLOR_W    = 8;

    typedef logic [PIX_ADDR_W-1:0] pix_addr_t;

    localparam pix_addr_t PIX_LIMIT = pix_addr_t'(PIX_COUNT);

    typedef struct packed {
        pix_addr_t          addr;
        logic [COLOR_W-1:0] color;
    } pix_entry_t;

    typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} wr_state_t;
endpackage

// File: rtl/pix_fifo.sv
// pix_fifo: synchronous FIFO of pix_entry_t with a combinational head read.
// Ports: clk, rst (async active-high), push/din write, pop advances the head,
// dout is the current head, count/full/empty report occupancy.
module pix_fifo
    import gpu_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  pix_entry_t             din,
    output pix_entry_t             dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);

    pix_entry_t     mem_q [DEPTH];
    logic [AW-1:0]  wr_q;
    logic [AW-1:0]  rd_q;
    logic [AW:0]    cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= din;
    end

    assign dout  = mem_q[rd_q];
    assign count = cnt_q;
    assign full  = cnt_q == (AW+1)'(DEPTH);
    assign empty = cnt_q == '0;
endmodule

// File: rtl/pixel_writer.sv
// pixel_writer: buffers rasterised pixels and drains them to framebuffer SRAM.
// Ports: addr_in/color_in/addr_valid/line_done_in from the line generator,
// stop throttles it; mem_addr/mem_wdata/mem_we/mem_ack form the SRAM write
// port; write_done pulses once a line is committed; busy, err_oob, err_ovf
// report status, err_clr clears the sticky errors.
module pixel_writer
    import gpu_pkg::*;
#(
    parameter int          DEPTH       = 8,
    parameter int          STOP_MARGIN = 2,
    parameter logic [19:0] FB_BASE     = 20'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [18:0] addr_in,
    input  logic        addr_valid,
    input  logic [7:0]  color_in,
    input  logic        line_done_in,
    output logic        stop,
    output logic [19:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    input  logic        mem_ack,
    output logic        write_done,
    output logic        busy,
    output logic        err_oob,
    output logic        err_ovf,
    input  logic        err_clr
);
    localparam int CW = $clog2(DEPTH) + 1;

    wr_state_t  state_q, state_d;
    logic       pending_q, pending_d;
    logic       stop_q, stop_d;
    logic       oob_q, oob_d;
    logic       ovf_q, ovf_d;
    logic       in_range, push, pop, done, full, empty;
    logic [CW-1:0] count, count_next;
    pix_entry_t head;

    pix_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   ('{addr: addr_in, color: color_in}),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // The entry being written stays at the FIFO head until acked, so the
    // SRAM port is driven straight from the head and a pop exposes the next.
    always_comb begin
        in_range   = addr_in < PIX_LIMIT;
        push       = addr_valid & in_range & ~full;
        pop        = (state_q == WRITE) & mem_ack;
        done       = pending_q & empty & (state_q == IDLE) & ~push;
        count_next = count + CW'(push) - CW'(pop);
        stop_d     = (DEPTH - int'(count_next)) <= STOP_MARGIN;
        state_d    = (state_q == IDLE) ? (empty ? IDLE : WRITE)
                                       : ((pop && count_next == '0) ? IDLE : WRITE);
        pending_d  = done ? 1'b0 : (pending_q | line_done_in);
        oob_d      = (oob_q & ~err_clr) | (addr_valid & ~in_range);
        ovf_d      = (ovf_q & ~err_clr) | (addr_valid & in_range & full);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
            stop_q    <= 1'b0;
            oob_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            stop_q    <= stop_d;
            oob_q     <= oob_d;
            ovf_q     <= ovf_d;
        end
    end

    assign mem_we     = state_q == WRITE;
    assign mem_addr   = mem_we ? {1'b0, head.addr} + FB_BASE : '0;
    assign mem_wdata  = mem_we ? head.color : '0;
    assign stop       = stop_q;
    assign write_done = done;
    assign busy       = ~empty | mem_we | pending_q;
    assign err_oob    = oob_q;
    assign err_ovf    = ovf_q;
endmodule

// File: tb/tb_pixel_writer.sv
// tb_pixel_writer: directed scenario bench for pixel_writer.
module tb_pixel_writer;
    logic        clk = 1'b0;
    logic        rst;
    logic [18:0] addr_in;
    logic        addr_valid;
    logic [7:0]  color_in;
    logic        line_done_in;
    logic        mem_ack;
    logic        err_clr;
    logic        stop, mem_we, write_done, busy, err_oob, err_ovf;
    logic [19:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        b_stop, b_mem_we, b_write_done, b_busy, b_err_oob, b_err_ovf;
    logic [19:0] b_mem_addr;
    logic [7:0]  b_mem_wdata;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    logic [19:0] wq[$];
    logic [7:0]  dq[$];

    always #5 clk = ~clk;

    pixel_writer dut (
        .clk(clk), .rst(rst), .addr_in(addr_in), .addr_valid(addr_valid),
        .color_in(color_in), .line_done_in(line_done_in), .stop(stop),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_ack(mem_ack), .write_done(write_done), .busy(busy),
        .err_oob(err_oob), .err_ovf(err_ovf), .err_clr(err_clr)
    );

    pixel_writer #(.FB_BASE(20'h40000)) dut_b (
        .clk(clk), .rst(rst), .addr_in(addr_in), .addr_valid(addr_valid),
        .color_in(color_in), .line_done_in(line_done_in), .stop(b_stop),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_we(b_mem_we),
        .mem_ack(mem_ack), .write_done(b_write_done), .busy(b_busy),
        .err_oob(b_err_oob), .err_ovf(b_err_ovf), .err_clr(err_clr)
    );

    always @(posedge clk) begin
        if (!rst) begin
            if (mem_we && mem_ack) begin
                wq.push_back(mem_addr);
                dq.push_back(mem_wdata);
            end
            if (write_done) done_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        addr_valid = 1'b1; addr_in = 19'd10; color_in = 8'h01; step();
        addr_in = 19'd400000; step();
        addr_valid = 1'b0; step();
        checks++; if (err_oob !== 1'b1) begin errors++; $display("FAIL reset_pre_oob: got %b want 1", err_oob); end
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL reset_pre_we: got %b want 1", mem_we); end
        #2 rst = 1'b1;
        #1;
        checks++; if ({stop, mem_we, write_done, busy, err_oob, err_ovf} !== 6'b0)
            begin errors++; $display("FAIL reset_async: got %b want 000000", {stop, mem_we, write_done, busy, err_oob, err_ovf}); end
        step(); rst = 1'b0; step();
        checks++; if ({busy, mem_we, stop, err_oob} !== 4'b0) begin errors++; $display("FAIL reset_release: got %b want 0000", {busy, mem_we, stop, err_oob}); end
    endtask

    task automatic test_single();
        int w0 = wq.size();
        int d0 = done_cnt;
        mem_ack = 1'b0;
        addr_valid = 1'b1; addr_in = 19'd321; color_in = 8'hA5; step();
        addr_valid = 1'b0;
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL single_latency0: got %b want 0", mem_we); end
        step();
        for (int c = 0; c < 3; c++) begin
            if (c == 2) mem_ack = 1'b1;
            checks++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 20'd321, 8'hA5})
                begin errors++; $display("FAIL single_hold%0d: got we=%b addr=%0d data=%h want 1/321/a5", c, mem_we, mem_addr, mem_wdata); end
            checks++; if (write_done !== 1'b0) begin errors++; $display("FAIL single_early_done%0d: got %b want 0", c, write_done); end
            if (c < 2) step();
        end
        step(); mem_ack = 1'b0;
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL single_we_drop: got %b want 0", mem_we); end
        checks++; if (wq.size() - w0 !== 1) begin errors++; $display("FAIL single_writes: got %0d want 1", wq.size() - w0); end
        checks++; if (wq.size() > w0 && wq[w0] !== 20'd321) begin errors++; $display("FAIL single_waddr: got %0d want 321", wq[w0]); end
        line_done_in = 1'b1; step(); line_done_in = 1'b0;
        checks++; if (write_done !== 1'b1) begin errors++; $display("FAIL single_done: got %b want 1", write_done); end
        step();
        checks++; if ({write_done, busy} !== 2'b00) begin errors++; $display("FAIL single_done_end: got %b want 00", {write_done, busy}); end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL single_done_cnt: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_backpressure();
        int w0 = wq.size();
        mem_ack = 1'b0;
        for (int i = 0; i < 8; i++) begin
            addr_valid = 1'b1; addr_in = 19'(1000 + i); color_in = 8'(i); step();
            checks++; if (stop !== (i >= 5)) begin errors++; $display("FAIL bp_stop_fill%0d: got %b want %b", i, stop, (i >= 5)); end
        end
        checks++; if (err_ovf !== 1'b0) begin errors++; $display("FAIL bp_ovf_early: got %b want 0", err_ovf); end
        addr_in = 19'd2000; step(); addr_valid = 1'b0;
        checks++; if ({err_ovf, stop} !== 2'b11) begin errors++; $display("FAIL bp_ovf: got %b want 11", {err_ovf, stop}); end
        mem_ack = 1'b1;
        for (int j = 0; j < 8; j++) begin
            step();
            checks++; if (stop !== (j < 2)) begin errors++; $display("FAIL bp_stop_drain%0d: got %b want %b", j, stop, (j < 2)); end
        end
        mem_ack = 1'b0;
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL bp_we_end: got %b want 0", mem_we); end
        checks++; if (wq.size() - w0 !== 8) begin errors++; $display("FAIL bp_writes: got %0d want 8", wq.size() - w0); end
        for (int k = 0; k < 8; k++) begin
            if (w0 + k < wq.size()) begin
                checks++; if ({wq[w0+k], dq[w0+k]} !== {20'(1000 + k), 8'(k)})
                    begin errors++; $display("FAIL bp_order%0d: got %0d/%h want %0d/%h", k, wq[w0+k], dq[w0+k], 1000 + k, k); end
            end
        end
        err_clr = 1'b1; step(); err_clr = 1'b0;
        checks++; if (err_ovf !== 1'b0) begin errors++; $display("FAIL bp_ovf_clr: got %b want 0", err_ovf); end
    endtask

    task automatic test_oob();
        int w0 = wq.size();
        mem_ack = 1'b1;
        addr_valid = 1'b1; addr_in = 19'd307199; color_in = 8'h11; step();
        addr_in = 19'd307200; color_in = 8'h22; step();
        addr_valid = 1'b0;
        checks++; if (err_oob !== 1'b1) begin errors++; $display("FAIL oob_set: got %b want 1", err_oob); end
        step(); step(); step();
        checks++; if (wq.size() - w0 !== 1) begin errors++; $display("FAIL oob_writes: got %0d want 1", wq.size() - w0); end
        checks++; if (wq.size() > w0 && {wq[w0], dq[w0]} !== {20'd307199, 8'h11})
            begin errors++; $display("FAIL oob_waddr: got %0d/%h want 307199/11", wq[w0], dq[w0]); end
        checks++; if (err_oob !== 1'b1) begin errors++; $display("FAIL oob_sticky: got %b want 1", err_oob); end
        err_clr = 1'b1; addr_valid = 1'b1; addr_in = 19'd307201; step();
        err_clr = 1'b0; addr_valid = 1'b0;
        checks++; if (err_oob !== 1'b1) begin errors++; $display("FAIL oob_clr_race: got %b want 1", err_oob); end
        err_clr = 1'b1; step(); err_clr = 1'b0;
        checks++; if (err_oob !== 1'b0) begin errors++; $display("FAIL oob_clr: got %b want 0", err_oob); end
    endtask

    task automatic test_back_to_back();
        int w0 = wq.size();
        int d0 = done_cnt;
        mem_ack = 1'b1;
        addr_valid = 1'b1; addr_in = 19'd50; color_in = 8'h50; step();
        addr_in = 19'd51; color_in = 8'h51; line_done_in = 1'b1; step();
        addr_valid = 1'b0;
        checks++; if ({write_done, mem_we, mem_addr} !== {1'b0, 1'b1, 20'd50})
            begin errors++; $display("FAIL b2b_first: got done=%b we=%b addr=%0d want 0/1/50", write_done, mem_we, mem_addr); end
        step(); line_done_in = 1'b0;
        checks++; if ({write_done, mem_we, mem_addr} !== {1'b0, 1'b1, 20'd51})
            begin errors++; $display("FAIL b2b_second: got done=%b we=%b addr=%0d want 0/1/51", write_done, mem_we, mem_addr); end
        step();
        checks++; if ({write_done, mem_we} !== 2'b10) begin errors++; $display("FAIL b2b_done: got %b want 10", {write_done, mem_we}); end
        checks++; if (wq.size() - w0 !== 2) begin errors++; $display("FAIL b2b_writes: got %0d want 2", wq.size() - w0); end
        step();
        checks++; if ({write_done, busy} !== 2'b00) begin errors++; $display("FAIL b2b_done_end: got %b want 00", {write_done, busy}); end
        step(); step();
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL b2b_done_cnt: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_fb_base();
        mem_ack = 1'b1;
        addr_valid = 1'b1; addr_in = 19'd639; color_in = 8'h7E; step();
        addr_valid = 1'b0; step();
        checks++; if ({b_mem_we, b_mem_addr, b_mem_wdata} !== {1'b1, 20'h4027F, 8'h7E})
            begin errors++; $display("FAIL fb_base: got we=%b addr=%h data=%h want 1/4027f/7e", b_mem_we, b_mem_addr, b_mem_wdata); end
        checks++; if (mem_addr !== 20'd639) begin errors++; $display("FAIL fb_zero: got %h want 0027f", mem_addr); end
        step();
        checks++; if (b_mem_we !== 1'b0) begin errors++; $display("FAIL fb_we_end: got %b want 0", b_mem_we); end
        mem_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; addr_in = '0; addr_valid = 1'b0; color_in = '0;
        line_done_in = 1'b0; mem_ack = 1'b0; err_clr = 1'b0;
        step(); step();
        rst = 1'b0;
        step();
        test_reset();
        test_single();
        test_backpressure();
        test_oob();
        test_back_to_back();
        test_fb_base();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
